// File: rtl/core_control_fsm.sv
// core_control_fsm: multi-cycle instruction sequencer for a small RISC core.
// Walks each instruction through FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK.
// It bounds each memory handshake with a wait counter and parks in TRAP on an
// illegal opcode or a memory timeout.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   run                           permit fetch of a new instruction
//   instr_type[2:0]               decoder instruction class (7 = illegal)
//   save_to_reg, rd_memory,
//   wr_memory, is_branch, inc_pc  decoder flags for the instruction in IR
//   branch_taken                  ALU branch compare result
//   imem_ack, dmem_ack            memory acknowledge strobes
//   imem_req, dmem_req, dmem_we   memory request strobes / data write qualifier
//   ir_load, rf_we, pc_we, pc_sel IR capture, RF write, PC update, PC source
//   state[2:0]                    current state encoding
//   halted                        high while in TRAP
//   trap_cause[1:0]               0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
//   retire_count[RETIRE_W-1:0]    instructions that completed WRITEBACK
module core_control_fsm #(
  parameter int unsigned RETIRE_W = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [2:0]          instr_type,
  input  logic                save_to_reg,
  input  logic                rd_memory,
  input  logic                wr_memory,
  input  logic                is_branch,
  input  logic                inc_pc,
  input  logic                branch_taken,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_load,
  output logic                rf_we,
  output logic                pc_we,
  output logic                pc_sel,
  output logic [2:0]          state,
  output logic                halted,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam int unsigned WAIT_W = 8;
  // Last ack-less cycle allowed before a timeout trap is taken.
  localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(TIMEOUT - 1);
  localparam logic [2:0]        INSTR_ILLEGAL = 3'd7;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [1:0]          cause_q, cause_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      cause_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cause_q  <= cause_d;
      retire_q <= retire_d;
    end
  end

  // Next-state, trap cause, retire and wait-counter update.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    retire_d = retire_q;
    wait_d   = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Ack wins over a timeout landing in the same cycle.
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM;
        end
      end
      ST_DECODE: begin
        if (instr_type == INSTR_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = (rd_memory || wr_memory) ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_WRITEBACK;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      ST_WRITEBACK: begin
        retire_d = retire_q + RETIRE_W'(1);
        state_d  = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counter is zero on every state change, so each FETCH/MEM visit starts fresh.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Strobe decode; everything defaults low.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = wr_memory;
      end
      ST_WRITEBACK: begin
        pc_we  = 1'b1;
        rf_we  = save_to_reg | rd_memory;
        pc_sel = is_branch & (inc_pc | branch_taken);
      end
      default: begin
      end
    endcase
  end

  assign state        = state_q;
  assign halted       = (state_q == ST_TRAP);
  assign trap_cause   = cause_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// Directed bench for core_control_fsm: per-cycle expected observations are
// queued as stimulus is driven and popped/compared at the falling edge.
module tb_core_control_fsm;

  localparam int TO = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] s;     // {imem_req,dmem_req,dmem_we,ir_load,rf_we,pc_we,pc_sel}
    logic       halted;
    logic [1:0] cause;
    logic [3:0] ret;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic [2:0] instr_type;
  logic save_to_reg, rd_memory, wr_memory, is_branch, inc_pc, branch_taken;
  logic imem_ack, dmem_ack;
  logic imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel;
  logic [2:0] state;
  logic halted;
  logic [1:0] trap_cause;
  logic [3:0] retire_count;

  obs_t exp_q[$];
  logic [3:0] exp_ret;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_control_fsm #(.RETIRE_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_type(instr_type),
    .save_to_reg(save_to_reg), .rd_memory(rd_memory), .wr_memory(wr_memory),
    .is_branch(is_branch), .inc_pc(inc_pc), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .halted(halted), .trap_cause(trap_cause),
    .retire_count(retire_count)
  );

  function automatic logic [6:0] mk_s(input logic ir, dr, dw, il, rw, pw, ps);
    return {ir, dr, dw, il, rw, pw, ps};
  endfunction

  // Queue one expected observation, compare at the falling edge, advance to just after the next rising edge.
  task automatic chk(input string tag, input logic [2:0] st, input logic [6:0] s,
                     input logic h, input logic [1:0] c);
    obs_t e, o;
    exp_q.push_back('{st: st, s: s, halted: h, cause: c, ret: exp_ret});
    @(negedge clk);
    o = '{st: state, s: {imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel},
          halted: halted, cause: trap_cause, ret: retire_count};
    e = exp_q.pop_front();
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed st=%0d s=%b h=%b cause=%0d ret=%0d expected st=%0d s=%b h=%b cause=%0d ret=%0d",
                tag, o.st, o.s, o.halted, o.cause, o.ret, e.st, e.s, e.halted, e.cause, e.ret);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_trap(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) chk("trap", S_TRAP, 7'b0, 1'b1, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_ret = '0;
    chk("reset", S_IDLE, 7'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    run = 1'b0;
    chk("post_reset_idle", S_IDLE, 7'b0, 1'b0, 2'd0);
  endtask

  // Entered in the first FETCH cycle. fl = {save,rd,wr,br,inc}.
  // iw/dw: ack-less cycles before the ack (>= TO: never ack; dw < 0: stop mid-MEM).
  task automatic run_instr(input logic [2:0] ty, input logic [4:0] fl, input logic tk,
                           input int iw, input int dw, input logic run_nxt);
    logic sv, rd, wr, br, inc;
    {sv, rd, wr, br, inc} = fl;
    instr_type = ty;
    {save_to_reg, rd_memory, wr_memory, is_branch, inc_pc} = fl;
    branch_taken = tk;
    run = 1'b0;  // must not matter outside IDLE/WRITEBACK
    for (int k = 0; k < TO; k++) begin
      imem_ack = (k == iw);
      chk("fetch", S_FETCH, mk_s(1'b1, 1'b0, 1'b0, imem_ack, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0);
      if (k == iw) break;
    end
    imem_ack = 1'b0;
    if (iw >= TO) begin
      chk_trap(2'd2, 5);
      return;
    end
    chk("decode", S_DECODE, 7'b0, 1'b0, 2'd0);
    if (ty == 3'd7) begin
      chk_trap(2'd1, 20);
      return;
    end
    chk("execute", S_EXEC, 7'b0, 1'b0, 2'd0);
    if (rd || wr) begin
      for (int k = 0; k < TO; k++) begin
        dmem_ack = (k == dw);
        chk("mem", S_MEM, mk_s(1'b0, 1'b1, wr, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 2'd0);
        if (dw < 0 && k == 1) return;
        if (k == dw) break;
      end
      dmem_ack = 1'b0;
      if (dw >= TO) begin
        chk_trap(2'd3, 5);
        return;
      end
    end
    run = run_nxt;
    chk("writeback", S_WB, mk_s(1'b0, 1'b0, 1'b0, 1'b0, sv | rd, 1'b1, br & (inc | tk)), 1'b0, 2'd0);
    exp_ret = 4'(exp_ret + 4'd1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr_type = 3'd0;
    {save_to_reg, rd_memory, wr_memory, is_branch, inc_pc, branch_taken} = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_ret = '0;

    chk("reset", S_IDLE, 7'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    imem_ack = 1'b1;  // stray ack in IDLE
    chk("idle_stray_ack", S_IDLE, 7'b0, 1'b0, 2'd0);
    imem_ack = 1'b0;
    chk("idle_hold", S_IDLE, 7'b0, 1'b0, 2'd0);
    run = 1'b1;
    chk("idle_go", S_IDLE, 7'b0, 1'b0, 2'd0);

    dmem_ack = 1'b1;  // stray data ack throughout a non-memory instruction
    run_instr(3'd0, 5'b10000, 1'b0, 0, 0, 1'b1);  // ADD
    dmem_ack = 1'b0;
    run_instr(3'd1, 5'b01000, 1'b0, 2, 3, 1'b1);  // LOAD, dmem_ack on 4th MEM cycle
    run_instr(3'd2, 5'b00100, 1'b0, 0, 0, 1'b1);  // STORE
    run_instr(3'd3, 5'b00010, 1'b1, 0, 0, 1'b1);  // BRANCH taken
    run_instr(3'd3, 5'b00010, 1'b0, 1, 0, 1'b1);  // BRANCH not taken
    run_instr(3'd5, 5'b10011, 1'b0, 3, 0, 1'b1);  // JAL, imem_ack on 4th FETCH cycle
    run_instr(3'd4, 5'b10000, 1'b1, 0, 0, 1'b1);  // LUI, taken ignored without is_branch
    for (int i = 0; i < 9; i++)
      run_instr(3'd0, 5'b10000, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 0, i != 8);
    run = 1'b0;
    chk("idle_after_wrap", S_IDLE, 7'b0, 1'b0, 2'd0);
    run = 1'b1;
    chk("idle_go2", S_IDLE, 7'b0, 1'b0, 2'd0);
    run_instr(3'd0, 5'b10000, 1'b0, 0, 0, 1'b1);
    run_instr(3'd0, 5'b10000, 1'b0, TO, 0, 1'b1);  // imem timeout, retire held at 1
    do_reset();

    run = 1'b1;
    chk("idle_go3", S_IDLE, 7'b0, 1'b0, 2'd0);
    run_instr(3'd7, 5'b00000, 1'b0, 0, 0, 1'b1);   // illegal
    do_reset();

    run = 1'b1;
    chk("idle_go4", S_IDLE, 7'b0, 1'b0, 2'd0);
    run_instr(3'd1, 5'b11000, 1'b0, 0, TO, 1'b1);  // dmem timeout
    do_reset();

    run = 1'b1;
    chk("idle_go5", S_IDLE, 7'b0, 1'b0, 2'd0);
    run_instr(3'd2, 5'b00100, 1'b0, 0, -1, 1'b1);  // stopped mid-MEM by reset
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_control_fsm.md
CORE_CONTROL_FSM -- requirements
Module: core_control_fsm

Interface
REQ-001 The block SHALL have parameter RETIRE_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for a memory acknowledge (range 1..255).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 run  input  1  permits the fetch of a new instruction.
REQ-006 instr_type  input  3  instruction class from the opcode decoder: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-007 save_to_reg, rd_memory, wr_memory, is_branch, inc_pc  input  1 each  opcode decoder flags for the instruction held in IR.
REQ-008 branch_taken  input  1  branch comparison result from the ALU, valid in EXECUTE and WRITEBACK.
REQ-009 imem_ack, dmem_ack  input  1 each  memory acknowledge strobes.
REQ-010 imem_req, dmem_req, dmem_we  output  1 each  memory request strobes, with dmem_we as the data-memory write qualifier.
REQ-011 ir_load, rf_we, pc_we, pc_sel  output  1 each  IR capture, register write, PC update, and PC source (0 = PC+4, 1 = target).
REQ-012 state  output  3  current state encoding: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, WRITEBACK 5, TRAP 7.
REQ-013 halted  output  1  high while the FSM is in TRAP.
REQ-014 trap_cause  output  2  0 none, 1 illegal instruction, 2 instruction-memory timeout, 3 data-memory timeout.
REQ-015 retire_count  output  RETIRE_W  count of instructions that completed WRITEBACK.

Function
REQ-016 In IDLE, the FSM SHALL go to FETCH on the next edge when run=1; otherwise it SHALL remain in IDLE.
REQ-017 In FETCH, imem_req SHALL be 1 every cycle until imem_ack=1, and a run deassertion during FETCH SHALL be ignored.
REQ-018 In FETCH with imem_ack=1, ir_load SHALL be 1 in that same cycle (combinational), and the FSM SHALL go to DECODE.
REQ-019 DECODE SHALL last exactly one cycle and go to TRAP with trap_cause=1 when instr_type=7; otherwise it SHALL go to EXECUTE.
REQ-020 EXECUTE SHALL last exactly one cycle and go to MEM when rd_memory OR wr_memory; otherwise it SHALL go to WRITEBACK.
REQ-021 In MEM, dmem_req SHALL be 1 and dmem_we SHALL equal wr_memory until dmem_ack=1, after which the FSM SHALL go to WRITEBACK.
REQ-022 WRITEBACK SHALL last exactly one cycle with pc_we=1, rf_we = save_to_reg OR rd_memory, and pc_sel = is_branch AND (inc_pc OR branch_taken).
REQ-023 WRITEBACK SHALL increment retire_count by 1, wrapping modulo 2^RETIRE_W (all-ones to 0), and go to FETCH when run=1, else to IDLE.
REQ-024 A wait counter SHALL clear on each entry to FETCH or MEM and increment on every cycle there in which the acknowledge is low.
REQ-025 When the wait counter reaches TIMEOUT with the acknowledge still low, the FSM SHALL go to TRAP with trap_cause=2 (FETCH) or 3 (MEM), and an acknowledge in that same cycle SHALL take priority over the timeout.
REQ-026 In TRAP, all strobes (imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel) SHALL be 0, halted SHALL be 1, and trap_cause and retire_count SHALL hold; only reset exits TRAP.
REQ-027 Every strobe not explicitly driven high in the current state SHALL be 0.
REQ-028 Minimum latency from FETCH entry to the next FETCH entry SHALL be 4 cycles without MEM and 5 cycles with a one-cycle dmem_ack.
REQ-029 An ack arriving outside its own request state SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, all strobes 0, halted=0, trap_cause=0, retire_count=0, and the wait counter to 0, regardless of state, including mid-MEM with dmem_req high.
REQ-031 After rst_n rises, no request SHALL be issued until the first clk edge with run=1.

Verification
REQ-032 ADD instruction (instr_type=0, save_to_reg=1), run=1, imem_ack on the first FETCH cycle -> states 1,2,3,5,1; rf_we=1 and pc_we=1 in WRITEBACK; retire_count 0->1.
REQ-033 LOAD with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; rf_we=1 in WRITEBACK.
REQ-034 BRANCH with branch_taken=1 -> pc_sel=1; with branch_taken=0 -> pc_sel=0; JAL with branch_taken=0 -> pc_sel=1.
REQ-035 instr_type=7 -> TRAP after DECODE with halted=1 and trap_cause=1; strobes stay 0 for 20 cycles; rst_n pulse -> IDLE with trap_cause=0.
REQ-036 TIMEOUT=4 with imem_ack held low -> TRAP and trap_cause=2 after 4 request cycles; the same test with ack on the 4th cycle -> DECODE.
REQ-037 RETIRE_W=4 preloaded to 15 -> 16th retire wraps the count to 0; run=0 in WRITEBACK -> IDLE with imem_req=0.
